// File: rtl/credit_link_bridge.sv
`default_nettype none
// ============================================================================
// Module   : credit_link_bridge
// Brief    : Retimed, credit-flow-controlled link stage with per-channel
//            receive FIFO, downstream credit counter and credit return pipe.
// Revision : 1.0
// ============================================================================
module credit_link_bridge #(
    parameter int NUM_CHANNELS       = 1,
    parameter int FLIT_WIDTH         = 256,
    parameter int DEST_WIDTH         = 4,
    parameter int LINK_STAGES        = 2,
    parameter int BUF_DEPTH          = 6,
    parameter int DOWNSTREAM_CREDITS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*FLIT_WIDTH-1:0] data_in,
    input  logic [NUM_CHANNELS*DEST_WIDTH-1:0] dest_in,
    input  logic [NUM_CHANNELS-1:0]            is_tail_in,
    input  logic [NUM_CHANNELS-1:0]            send_in,
    output logic [NUM_CHANNELS-1:0]            credit_out,
    output logic [NUM_CHANNELS*FLIT_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS*DEST_WIDTH-1:0] dest_out,
    output logic [NUM_CHANNELS-1:0]            is_tail_out,
    output logic [NUM_CHANNELS-1:0]            send_out,
    input  logic [NUM_CHANNELS-1:0]            credit_in,
    output logic [NUM_CHANNELS-1:0]            error
);
    localparam int c_PAY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int c_CRD_W = $clog2(DOWNSTREAM_CREDITS + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CRD_W-1:0] c_CRD_MAX  = c_CRD_W'(DOWNSTREAM_CREDITS);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [c_PAY_W-1:0]     w_pay_in;
        logic                   w_wr_vld;
        logic [c_PAY_W-1:0]     w_wr_pay;
        logic [c_PAY_W-1:0]     r_mem [BUF_DEPTH];
        logic [c_PTR_W-1:0]     r_wr_ptr;
        logic [c_PTR_W-1:0]     r_rd_ptr;
        logic [c_CNT_W-1:0]     r_count;
        logic [c_CRD_W-1:0]     r_credits;
        logic                   w_full;
        logic                   w_issue;
        logic                   w_wr_en;
        logic                   w_drop;
        logic                   w_crd_ovf;
        logic                   r_send;
        logic [c_PAY_W-1:0]     r_pay_out;
        logic [LINK_STAGES-1:0] r_cpipe;
        logic                   r_err;

        assign w_pay_in = {is_tail_in[c], dest_in[c*DEST_WIDTH +: DEST_WIDTH],
                           data_in[c*FLIT_WIDTH +: FLIT_WIDTH]};

        // The FIFO write acts as the last forward stage, so only LINK_STAGES-1 explicit registers
        if (LINK_STAGES > 1) begin : g_fwd
            logic [LINK_STAGES-2:0] r_vld;
            logic [c_PAY_W-1:0]     r_pay [LINK_STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                    for (int i = 0; i < LINK_STAGES - 1; i++) r_pay[i] <= '0;
                end else begin
                    r_vld[0] <= send_in[c];
                    r_pay[0] <= w_pay_in;
                    for (int i = 1; i < LINK_STAGES - 1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_pay[i] <= r_pay[i-1];
                    end
                end
            end
            assign w_wr_vld = r_vld[LINK_STAGES-2];
            assign w_wr_pay = r_pay[LINK_STAGES-2];
        end else begin : g_nofwd
            assign w_wr_vld = send_in[c];
            assign w_wr_pay = w_pay_in;
        end

        // A credit arriving this cycle may be spent this cycle; a read frees a full slot first
        assign w_full    = (r_count == c_CNT_FULL);
        assign w_issue   = (r_count != '0) && ((r_credits != '0) || credit_in[c]);
        assign w_wr_en   = w_wr_vld && (!w_full || w_issue);
        assign w_drop    = w_wr_vld && w_full && !w_issue;
        assign w_crd_ovf = credit_in[c] && !w_issue && (r_credits == c_CRD_MAX);

        always_ff @(posedge clk) begin
            if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_pay;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_en) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                if (w_issue) r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
                r_count <= r_count + c_CNT_W'(w_wr_en) - c_CNT_W'(w_issue);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_credits <= c_CRD_MAX;
            end else if (w_issue && !credit_in[c]) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_issue && credit_in[c] && (r_credits != c_CRD_MAX)) begin
                r_credits <= r_credits + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_send    <= 1'b0;
                r_pay_out <= '0;
                r_cpipe   <= '0;
                r_err     <= 1'b0;
            end else begin
                r_send <= w_issue;
                if (w_issue) r_pay_out <= r_mem[r_rd_ptr];
                r_cpipe[0] <= r_send;
                for (int i = 1; i < LINK_STAGES; i++) r_cpipe[i] <= r_cpipe[i-1];
                r_err <= r_err | w_drop | w_crd_ovf;
            end
        end

        assign send_out[c]                             = r_send;
        assign data_out[c*FLIT_WIDTH +: FLIT_WIDTH]    = r_pay_out[FLIT_WIDTH-1:0];
        assign dest_out[c*DEST_WIDTH +: DEST_WIDTH]    = r_pay_out[FLIT_WIDTH +: DEST_WIDTH];
        assign is_tail_out[c]                          = r_pay_out[c_PAY_W-1];
        assign credit_out[c]                           = r_cpipe[LINK_STAGES-1];
        assign error[c]                                = r_err;
    end
endmodule
`default_nettype wire

// File: tb/tb_credit_link_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_link_bridge
// Brief    : Directed vector table, corner sequences and reference-model
//            random traffic for credit_link_bridge.
// Revision : 1.0
// ============================================================================
module tb_credit_link_bridge;
    localparam int NCH = 3;
    localparam int FW  = 32;
    localparam int DW  = 4;
    localparam int LS  = 2;
    localparam int BD  = 6;
    localparam int DC  = 2;
    localparam int PW  = FW + DW + 1;

    typedef logic [PW-1:0] pay_t;
    typedef struct { int due; pay_t p; } pend_t;
    typedef struct packed {
        logic          snd;
        logic [FW-1:0] d;
        logic          cin;
        logic          e_snd;
        logic [FW-1:0] e_d;
        logic          e_cout;
        logic          e_err;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH*FW-1:0]   data_in = '0;
    logic [NCH*DW-1:0]   dest_in = '0;
    logic [NCH-1:0]      is_tail_in = '0;
    logic [NCH-1:0]      send_in = '0;
    logic [NCH-1:0]      credit_out;
    logic [NCH*FW-1:0]   data_out;
    logic [NCH*DW-1:0]   dest_out;
    logic [NCH-1:0]      is_tail_out;
    logic [NCH-1:0]      send_out;
    logic [NCH-1:0]      credit_in = '0;
    logic [NCH-1:0]      error;

    credit_link_bridge #(
        .NUM_CHANNELS(NCH), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
        .LINK_STAGES(LS), .BUF_DEPTH(BD), .DOWNSTREAM_CREDITS(DC)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: flits in flight carry the cycle they land in the FIFO
    pend_t m_pend [NCH][$];
    pay_t  m_fifo [NCH][$];
    int    m_ret  [NCH][$];
    int    m_cred [NCH];
    bit    m_err  [NCH];
    bit    e_send [NCH];
    bit    e_cout [NCH];
    pay_t  e_pay  [NCH];
    int    mcyc;

    // Traffic generators and activity counters
    int up_cred[NCH], owed[NCH], sent_cnt[NCH], send_lim[NCH];
    bit cred_hold[NCH];
    int p_send, p_ret, p_rogue;
    int n_out[NCH], n_cout[NCH], first_out[NCH], last_out[NCH], pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pay_t mkpay(input logic [FW-1:0] d);
        return {d[0], d[3:0], d};
    endfunction

    function automatic pay_t out_pay(input int c);
        return {is_tail_out[c], dest_out[c*DW +: DW], data_out[c*FW +: FW]};
    endfunction

    task automatic set_ch(input int c, input logic s, input pay_t p, input logic ci);
        data_in[c*FW +: FW]  = p[FW-1:0];
        dest_in[c*DW +: DW]  = p[FW +: DW];
        is_tail_in[c]        = p[PW-1];
        send_in[c]           = s;
        credit_in[c]         = ci;
    endtask

    task automatic drive0(input logic s, input logic [FW-1:0] d, input logic ci);
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, '0, 1'b0);
        set_ch(0, s, mkpay(d), ci);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pend[c].delete(); m_fifo[c].delete(); m_ret[c].delete();
            m_cred[c] = DC; m_err[c] = 1'b0;
            e_send[c] = 1'b0; e_cout[c] = 1'b0; e_pay[c] = '0;
            up_cred[c] = BD; owed[c] = 0; sent_cnt[c] = 0;
        end
        mcyc = 0;
    endtask

    task automatic clear_act();
        for (int c = 0; c < NCH; c++) begin
            n_out[c] = 0; n_cout[c] = 0; first_out[c] = -1; last_out[c] = -1;
        end
        pc = 0;
    endtask

    // Assert reset at a negedge, verify cleared outputs, release at a later negedge
    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_send_out", 64'(send_out), 64'd0);
        chk("rst_credit_out", 64'(credit_out), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_fields", {61'd0, |data_out, |dest_out, |is_tail_out}, 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_step(input logic [NCH-1:0] s, input logic [NCH-1:0][PW-1:0] p,
                              input logic [NCH-1:0] ci);
        for (int c = 0; c < NCH; c++) begin
            bit    iss;
            pend_t pe;
            if (s[c]) m_pend[c].push_back('{due: mcyc + LS - 1, p: p[c]});
            iss = (m_fifo[c].size() > 0) && (m_cred[c] + int'(ci[c]) > 0);
            m_cred[c] += int'(ci[c]) - int'(iss);
            if (m_cred[c] > DC) begin
                m_cred[c] = DC;
                m_err[c]  = 1'b1;
            end
            e_send[c] = iss;
            if (iss) begin
                e_pay[c] = m_fifo[c].pop_front();
                m_ret[c].push_back(mcyc + 1 + LS);
            end
            while (m_pend[c].size() > 0 && m_pend[c][0].due == mcyc) begin
                pe = m_pend[c].pop_front();
                if (m_fifo[c].size() < BD) m_fifo[c].push_back(pe.p);
                else m_err[c] = 1'b1;
            end
            e_cout[c] = 1'b0;
            if (m_ret[c].size() > 0 && m_ret[c][0] == mcyc + 1) begin
                e_cout[c] = 1'b1;
                void'(m_ret[c].pop_front());
            end
        end
        mcyc++;
    endtask

    task automatic model_cycle();
        logic [NCH-1:0]         s, ci;
        logic [NCH-1:0][PW-1:0] p;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("m_send%0d", c), 64'(send_out[c]), 64'(e_send[c]));
            chk($sformatf("m_cout%0d", c), 64'(credit_out[c]), 64'(e_cout[c]));
            chk($sformatf("m_err%0d", c), 64'(error[c]), 64'(m_err[c]));
            if (e_send[c]) chk($sformatf("m_pay%0d", c), 64'(out_pay(c)), 64'(e_pay[c]));
            if (send_out[c]) begin
                n_out[c]++;
                if (first_out[c] < 0) first_out[c] = pc;
                last_out[c] = pc;
            end
            if (credit_out[c]) n_cout[c]++;
            up_cred[c] += int'(credit_out[c]);
            ci[c] = 1'b0;
            if (!cred_hold[c] && owed[c] > 0 && $urandom_range(99) < p_ret) begin
                ci[c] = 1'b1;
                owed[c]--;
            end else if ($urandom_range(999) < p_rogue) begin
                ci[c] = 1'b1;
            end
            owed[c] += int'(send_out[c]);
            s[c] = 1'b0;
            if (sent_cnt[c] < send_lim[c] && $urandom_range(99) < p_send &&
                (up_cred[c] > 0 || $urandom_range(999) < p_rogue)) begin
                s[c] = 1'b1;
                up_cred[c]--;
                sent_cnt[c]++;
            end
            p[c] = pay_t'({$urandom, $urandom});
            set_ch(c, s[c], p[c], ci[c]);
        end
        model_step(s, p, ci);
        pc++;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [40];
        pay_t exp_q [$];
        int   got;

        // Directed table on channel 0: single flit, credit starvation, saturation
        for (int i = 0; i < 40; i++) tbl[i] = '0;
        tbl[10].snd = 1'b1; tbl[10].d = 32'h1234_5603;
        tbl[13].e_snd = 1'b1; tbl[13].e_d = 32'h1234_5603;
        tbl[14].cin = 1'b1;
        tbl[15].e_cout = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tbl[20+j].snd = 1'b1;
            tbl[20+j].d   = 32'hAB00_0021 + 32'(j);
        end
        tbl[23].e_snd = 1'b1; tbl[23].e_d = 32'hAB00_0021;
        tbl[24].e_snd = 1'b1; tbl[24].e_d = 32'hAB00_0022;
        tbl[25].e_cout = 1'b1; tbl[26].e_cout = 1'b1;
        tbl[28].cin = 1'b1;
        tbl[29].e_snd = 1'b1; tbl[29].e_d = 32'hAB00_0023;
        tbl[31].e_cout = 1'b1;
        tbl[34].cin = 1'b1;
        tbl[35].e_snd = 1'b1; tbl[35].e_d = 32'hAB00_0024;
        tbl[37].e_cout = 1'b1;
        tbl[36].cin = 1'b1; tbl[37].cin = 1'b1; tbl[38].cin = 1'b1;
        tbl[39].e_err = 1'b1;

        do_reset();
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("tbl%0d_send", i), 64'(send_out[0]), 64'(tbl[i].e_snd));
            chk($sformatf("tbl%0d_cout", i), 64'(credit_out[0]), 64'(tbl[i].e_cout));
            chk($sformatf("tbl%0d_err", i), 64'(error[0]), 64'(tbl[i].e_err));
            if (tbl[i].e_snd)
                chk($sformatf("tbl%0d_pay", i), 64'(out_pay(0)), 64'(mkpay(tbl[i].e_d)));
            drive0(tbl[i].snd, tbl[i].d, tbl[i].cin);
            @(negedge clk);
        end

        // Same-cycle credit_in and issue with one credit left keeps the count at one
        do_reset();
        for (int k = 0; k < 11; k++) begin
            if (k == 3) chk("same_send_a1", 64'(out_pay(0)) | {63'd0, ~send_out[0]},
                            64'(mkpay(32'h5A00_0001)));
            if (k == 4) chk("same_send_a2", 64'(out_pay(0)) | {63'd0, ~send_out[0]},
                            64'(mkpay(32'h5A00_0002)));
            if (k == 8) chk("same_send_a3", 64'(send_out[0]), 64'd1);
            if (k == 9 || k == 10) chk($sformatf("same_hold%0d", k), 64'(send_out[0]), 64'd0);
            if (k == 10) chk("same_err", 64'(error[0]), 64'd0);
            case (k)
                0:       drive0(1'b1, 32'h5A00_0001, 1'b0);
                1:       drive0(1'b1, 32'h5A00_0002, 1'b0);
                3:       drive0(1'b0, '0, 1'b1);
                5:       drive0(1'b1, 32'h5A00_0003, 1'b0);
                6:       drive0(1'b1, 32'h5A00_0005, 1'b0);
                default: drive0(1'b0, '0, 1'b0);
            endcase
            @(negedge clk);
        end

        // Credit_in at full count sets error and the count saturates at DC
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) chk("sat_err_before", 64'(error[0]), 64'd0);
            if (k == 1) chk("sat_err_after", 64'(error[0]), 64'd1);
            if (k == 4 || k == 5) chk($sformatf("sat_send%0d", k), 64'(send_out[0]), 64'd1);
            if (k == 6 || k == 7) chk($sformatf("sat_idle%0d", k), 64'(send_out[0]), 64'd0);
            case (k)
                0:          drive0(1'b0, '0, 1'b1);
                1, 2, 3:    drive0(1'b1, 32'h7700_0000 + 32'(k), 1'b0);
                default:    drive0(1'b0, '0, 1'b0);
            endcase
            @(negedge clk);
        end

        // Overflow: seven flits into six slots with credits exhausted
        do_reset();
        exp_q.delete();
        got = 0;
        for (int j = 0; j < 6; j++) exp_q.push_back(mkpay(32'hCC00_0000 + 32'(j)));
        for (int k = 0; k < 34; k++) begin
            if (k == 3 || k == 4) chk($sformatf("ovf_pre%0d", k), 64'(send_out[0]), 64'd1);
            if (k >= 5 && k <= 16) chk($sformatf("ovf_idle%0d", k), 64'(send_out[0]), 64'd0);
            if (k == 13) chk("ovf_err_before", 64'(error[0]), 64'd0);
            if (k == 14) chk("ovf_err_after", 64'(error[0]), 64'd1);
            if (k > 16 && send_out[0]) begin
                if (exp_q.size() > 0) chk($sformatf("ovf_pay%0d", got), 64'(out_pay(0)),
                                          64'(exp_q.pop_front()));
                got++;
            end
            if (k < 2)                 drive0(1'b1, 32'hDD00_0000 + 32'(k), 1'b0);
            else if (k >= 6 && k <= 12) drive0(1'b1, 32'hCC00_0000 + 32'(k - 6), 1'b0);
            else if (k >= 16 && k <= 29) drive0(1'b0, '0, 1'b1);
            else                       drive0(1'b0, '0, 1'b0);
            @(negedge clk);
        end
        chk("ovf_count", 64'(got), 64'd6);

        // Streaming on all channels with immediate credit return
        do_reset();
        clear_act();
        for (int c = 0; c < NCH; c++) begin
            send_lim[c] = 100; cred_hold[c] = 1'b0;
        end
        p_send = 100; p_ret = 100; p_rogue = 0;
        for (int k = 0; k < 130; k++) model_cycle();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("stream_n%0d", c), 64'(n_out[c]), 64'd100);
            chk($sformatf("stream_rate%0d", c), 64'(last_out[c] - first_out[c]), 64'd99);
            chk($sformatf("stream_cout%0d", c), 64'(n_cout[c]), 64'd100);
        end

        // Channel 0 starved while channel 1 streams, then reset mid-packet
        do_reset();
        cred_hold[0] = 1'b1; send_lim[0] = 4;
        cred_hold[1] = 1'b0; send_lim[1] = 1000;
        cred_hold[2] = 1'b0; send_lim[2] = 0;
        for (int k = 0; k < 25; k++) model_cycle();
        do_reset();
        clear_act();
        send_lim[0] = 3; send_lim[1] = 0;
        for (int k = 0; k < 20; k++) model_cycle();
        chk("post_rst_ch0_out", 64'(n_out[0]), 64'd2);
        chk("post_rst_ch1_out", 64'(n_out[1]), 64'd0);

        // Random traffic with occasional protocol violations and a reset in between
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            send_lim[c] = 1000000; cred_hold[c] = 1'b0;
        end
        p_send = 60; p_ret = 50; p_rogue = 5;
        for (int k = 0; k < 400; k++) model_cycle();
        do_reset();
        for (int k = 0; k < 400; k++) model_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
